// File: rtl/wb_select_pipe_pkg.sv
// wb_select_pipe_pkg: shared encodings and default memory map for the writeback pipe
//   wb_sel_e      writeback source select (NONE/ALU/MEM/PC)
//   F3_*          load funct3 encodings
//   DEF_*         default width and tag-decode parameters
package wb_select_pipe_pkg;
   typedef enum logic [1:0] {
      WB_NONE = 2'b00,
      WB_ALU  = 2'b01,
      WB_MEM  = 2'b10,
      WB_PC   = 2'b11
   } wb_sel_e;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam int DEF_XLEN  = 32;
   localparam int DEF_N_SRC = 3;
   localparam int DEF_TAG_W = 4;
   // src0 dmem, src1 bios, src2 io; src0 sits in the LSBs
   localparam logic [DEF_N_SRC*DEF_TAG_W-1:0] DEF_SRC_TAG  = {4'b1000, 4'b0100, 4'b0001};
   localparam logic [DEF_N_SRC*DEF_TAG_W-1:0] DEF_SRC_MASK = {4'b1111, 4'b1111, 4'b1101};
endpackage

// File: rtl/wb_select_pipe_load_align.sv
// wb_select_pipe_load_align: combinational load byte/half/word extraction and extension
//   word_i      raw 32-bit word from the selected source
//   lo_i        address bits [1:0]
//   funct3_i    load type
//   data_o      aligned, extended data (0 when misalign_o)
//   misalign_o  misaligned access or undefined load type
module wb_select_pipe_load_align
   import wb_select_pipe_pkg::*;
#(
   parameter int XLEN = DEF_XLEN
) (
   input  logic [XLEN-1:0] word_i,
   input  logic [1:0]      lo_i,
   input  logic [2:0]      funct3_i,
   output logic [XLEN-1:0] data_o,
   output logic            misalign_o
);
   logic [7:0]      byte_w;
   logic [15:0]     half_w;
   logic [XLEN-1:0] ext_w;
   assign byte_w = word_i[{lo_i, 3'b000} +: 8];
   assign half_w = lo_i[1] ? word_i[16 +: 16] : word_i[0 +: 16];
   assign ext_w  = (funct3_i == F3_LB)  ? {{(XLEN-8){byte_w[7]}}, byte_w} :
                   (funct3_i == F3_LBU) ? {{(XLEN-8){1'b0}}, byte_w} :
                   (funct3_i == F3_LH)  ? {{(XLEN-16){half_w[15]}}, half_w} :
                   (funct3_i == F3_LHU) ? {{(XLEN-16){1'b0}}, half_w} :
                   (funct3_i == F3_LW)  ? word_i : '0;
   // undefined funct3 is folded into the error flag so the caller sees one fault bit
   assign misalign_o = (((funct3_i == F3_LH) || (funct3_i == F3_LHU)) && lo_i[0]) ||
                       ((funct3_i == F3_LW) && (lo_i != 2'b00)) ||
                       !((funct3_i == F3_LB) || (funct3_i == F3_LBU) || (funct3_i == F3_LH) ||
                         (funct3_i == F3_LHU) || (funct3_i == F3_LW));
   assign data_o = misalign_o ? '0 : ext_w;
endmodule

// File: rtl/wb_select_pipe.sv
// wb_select_pipe: two-stage writeback with tag-decoded memory select, load alignment and stall hold
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   x_*_i                         instruction entering stage 1
//   mem_rdata_i                   per-source read data, valid the cycle after issue
//   stall_i, flush_i              hold both stages / kill stage 1
//   fwd1_*_o, load_use_o          stage-1 bypass and load-use hazard
//   wb_*_o                        stage-2 register-file write
module wb_select_pipe
   import wb_select_pipe_pkg::*;
#(
   parameter int                         XLEN     = DEF_XLEN,
   parameter int                         N_SRC    = DEF_N_SRC,
   parameter int                         TAG_W    = DEF_TAG_W,
   parameter logic [N_SRC*TAG_W-1:0]     SRC_TAG  = DEF_SRC_TAG,
   parameter logic [N_SRC*TAG_W-1:0]     SRC_MASK = DEF_SRC_MASK
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  x_valid_i,
   input  logic [1:0]            x_wb_sel_i,
   input  logic [4:0]            x_rd_i,
   input  logic [2:0]            x_funct3_i,
   input  logic [XLEN-1:0]       x_addr_i,
   input  logic [XLEN-1:0]       x_pc_plus4_i,
   input  logic [N_SRC*XLEN-1:0] mem_rdata_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   output logic                  fwd1_valid_o,
   output logic [4:0]            fwd1_rd_o,
   output logic [XLEN-1:0]       fwd1_data_o,
   output logic                  load_use_o,
   output logic                  wb_valid_o,
   output logic                  wb_we_o,
   output logic [4:0]            wb_rd_o,
   output logic [XLEN-1:0]       wb_data_o,
   output logic                  wb_err_o
);
   logic            s1_valid_q, hold_valid_q, s2_valid_q, s2_err_q;
   wb_sel_e         s1_sel_q, s2_sel_q;
   logic [4:0]      s1_rd_q, s2_rd_q;
   logic [2:0]      s1_f3_q;
   logic [1:0]      s1_lo_q;
   logic [TAG_W-1:0] s1_tag_q;
   logic [XLEN-1:0] s1_alu_q, s1_pc4_q, hold_word_q, s2_data_q;
   logic [XLEN-1:0] raw_w, al_data_w, s2_data_d;
   logic            hit_w, al_bad_w, s2_err_d;
   // descending scan so the lowest-index hit is the one left standing
   always_comb begin
      raw_w = '0;
      hit_w = 1'b0;
      for (int i = N_SRC-1; i >= 0; i--)
         if ((s1_tag_q & SRC_MASK[i*TAG_W +: TAG_W]) == SRC_TAG[i*TAG_W +: TAG_W]) begin
            raw_w = mem_rdata_i[i*XLEN +: XLEN];
            hit_w = 1'b1;
         end
   end
   wb_select_pipe_load_align #(.XLEN(XLEN)) u_align (
      .word_i    (hold_valid_q ? hold_word_q : raw_w),
      .lo_i      (s1_lo_q),
      .funct3_i  (s1_f3_q),
      .data_o    (al_data_w),
      .misalign_o(al_bad_w)
   );
   assign s2_err_d  = (s1_sel_q == WB_MEM) && (!hit_w || al_bad_w);
   assign s2_data_d = (s1_sel_q == WB_ALU) ? s1_alu_q :
                      (s1_sel_q == WB_PC)  ? s1_pc4_q :
                      ((s1_sel_q == WB_MEM) && !s2_err_d) ? al_data_w : '0;
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s1_valid_q   <= 1'b0;
         s1_sel_q     <= WB_NONE;
         s1_rd_q      <= '0;
         s1_f3_q      <= '0;
         s1_lo_q      <= '0;
         s1_tag_q     <= '0;
         s1_alu_q     <= '0;
         s1_pc4_q     <= '0;
         hold_valid_q <= 1'b0;
         hold_word_q  <= '0;
      end else if (flush_i) begin
         s1_valid_q   <= 1'b0;
         hold_valid_q <= 1'b0;
      end else if (!stall_i) begin
         s1_valid_q   <= x_valid_i;
         hold_valid_q <= 1'b0;
         if (x_valid_i) begin
            s1_sel_q <= wb_sel_e'(x_wb_sel_i);
            s1_rd_q  <= x_rd_i;
            s1_f3_q  <= x_funct3_i;
            s1_lo_q  <= x_addr_i[1:0];
            s1_tag_q <= x_addr_i[XLEN-1 -: TAG_W];
            s1_alu_q <= x_addr_i;
            s1_pc4_q <= x_pc_plus4_i;
         end
      end else if (s1_valid_q && (s1_sel_q == WB_MEM) && !hold_valid_q) begin
         // read data is only guaranteed for one cycle, so capture it on stall entry
         hold_valid_q <= 1'b1;
         hold_word_q  <= raw_w;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         s2_valid_q <= 1'b0;
         s2_sel_q   <= WB_NONE;
         s2_rd_q    <= '0;
         s2_data_q  <= '0;
         s2_err_q   <= 1'b0;
      end else if (!stall_i) begin
         s2_valid_q <= s1_valid_q && !flush_i;
         s2_sel_q   <= s1_sel_q;
         s2_rd_q    <= s1_rd_q;
         s2_data_q  <= s2_data_d;
         s2_err_q   <= s2_err_d;
      end
   end
   assign fwd1_valid_o = s1_valid_q && ((s1_sel_q == WB_ALU) || (s1_sel_q == WB_PC)) && (s1_rd_q != 5'd0);
   assign fwd1_rd_o    = s1_rd_q;
   assign fwd1_data_o  = (s1_sel_q == WB_PC) ? s1_pc4_q : s1_alu_q;
   assign load_use_o   = s1_valid_q && (s1_sel_q == WB_MEM) && (s1_rd_q != 5'd0);
   assign wb_valid_o   = s2_valid_q;
   assign wb_we_o      = s2_valid_q && (s2_sel_q != WB_NONE) && (s2_rd_q != 5'd0) && !s2_err_q;
   assign wb_rd_o      = s2_rd_q;
   assign wb_data_o    = s2_data_q;
   assign wb_err_o     = s2_valid_q && s2_err_q;
endmodule

// File: tb/tb_wb_select_pipe.sv
// tb_wb_select_pipe: scoreboard bench for the writeback select pipe
module tb_wb_select_pipe;
   import wb_select_pipe_pkg::*;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        x_valid = 1'b0, stall = 1'b0, flush = 1'b0;
   logic [1:0]  x_sel = 2'b00;
   logic [4:0]  x_rd = '0;
   logic [2:0]  x_f3 = '0;
   logic [31:0] x_addr = '0, x_pc4 = '0;
   logic [95:0] mem = '0;
   logic        fwd1_valid, load_use, wb_valid, wb_we, wb_err;
   logic [4:0]  fwd1_rd, wb_rd;
   logic [31:0] fwd1_data, wb_data;
   typedef struct packed {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        err;
   } exp_t;
   exp_t sb[$];
   int   total = 0, bad = 0;
   logic adv = 1'b0;
   always #5 clk = ~clk;
   wb_select_pipe dut (
      .clk_i(clk), .rst_ni(rst_n), .x_valid_i(x_valid), .x_wb_sel_i(x_sel), .x_rd_i(x_rd),
      .x_funct3_i(x_f3), .x_addr_i(x_addr), .x_pc_plus4_i(x_pc4), .mem_rdata_i(mem),
      .stall_i(stall), .flush_i(flush), .fwd1_valid_o(fwd1_valid), .fwd1_rd_o(fwd1_rd),
      .fwd1_data_o(fwd1_data), .load_use_o(load_use), .wb_valid_o(wb_valid), .wb_we_o(wb_we),
      .wb_rd_o(wb_rd), .wb_data_o(wb_data), .wb_err_o(wb_err)
   );
   // a new stage-2 result appears only after an edge without stall or reset
   always @(posedge clk) adv = rst_n && !stall;
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && adv && wb_valid) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL wb_unexpected got we=%0b rd=%0d data=%h err=%0b, none expected", wb_we, wb_rd, wb_data, wb_err);
         end else begin
            e = sb.pop_front();
            if ({wb_we, wb_rd, wb_data, wb_err} !== {e.we, e.rd, e.data, e.err}) begin
               bad++;
               $display("FAIL wb_result got we=%0b rd=%0d data=%h err=%0b expected we=%0b rd=%0d data=%h err=%0b",
                        wb_we, wb_rd, wb_data, wb_err, e.we, e.rd, e.data, e.err);
            end
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   task automatic op(input logic [1:0] sel, input logic [4:0] rd, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] pc4, input logic push,
                     input logic we, input logic [31:0] data, input logic err);
      x_valid = 1'b1; x_sel = sel; x_rd = rd; x_f3 = f3; x_addr = addr; x_pc4 = pc4;
      if (push) sb.push_back('{we, rd, data, err});
   endtask
   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         x_valid = 1'b0;
      end
   endtask
   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      total += 3;
      if ({fwd1_valid, load_use, wb_valid, wb_we, wb_err} !== 5'b0) begin
         bad++; $display("FAIL reset_flags got %b expected 00000", {fwd1_valid, load_use, wb_valid, wb_we, wb_err});
      end
      if ({fwd1_rd, wb_rd} !== 10'b0) begin
         bad++; $display("FAIL reset_rd got %h expected 0", {fwd1_rd, wb_rd});
      end
      if ({fwd1_data, wb_data} !== 64'b0) begin
         bad++; $display("FAIL reset_data got %h expected 0", {fwd1_data, wb_data});
      end
      rst_n = 1'b1;
   endtask
   task automatic test_lw;
      mem = {32'hABCD_1234, 32'h1234_8765, 32'hDEAD_BEEF};
      @(negedge clk); op(WB_MEM, 5'd1, F3_LW, 32'h1000_0004, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
      @(negedge clk); x_valid = 1'b0;
      total += 2;
      if (wb_valid !== 1'b0) begin
         bad++; $display("FAIL lw_latency_early got wb_valid=%0b expected 0", wb_valid);
      end
      if (load_use !== 1'b1) begin
         bad++; $display("FAIL lw_load_use got %0b expected 1", load_use);
      end
      @(negedge clk);
      total++;
      if ({wb_valid, wb_we, wb_data} !== {1'b1, 1'b1, 32'hDEAD_BEEF}) begin
         bad++; $display("FAIL lw_latency got valid=%0b we=%0b data=%h expected 1 1 deadbeef", wb_valid, wb_we, wb_data);
      end
      idle(2);
   endtask
   task automatic test_align;
      mem = {32'hABCD_1234, 32'h1234_8765, 32'h80FF_7F01};
      @(negedge clk); op(WB_MEM, 5'd2,  F3_LB,  32'h3000_0003, 0, 1, 1, 32'hFFFF_FF80, 0);
      @(negedge clk); op(WB_MEM, 5'd3,  F3_LBU, 32'h3000_0003, 0, 1, 1, 32'h0000_0080, 0);
      @(negedge clk); op(WB_MEM, 5'd4,  F3_LH,  32'h4000_0001, 0, 1, 0, 32'h0, 1);
      @(negedge clk); op(WB_MEM, 5'd5,  F3_LW,  32'h2000_0000, 0, 1, 0, 32'h0, 1);
      @(negedge clk); op(WB_MEM, 5'd6,  F3_LH,  32'h8000_0002, 0, 1, 1, 32'hFFFF_ABCD, 0);
      @(negedge clk); op(WB_MEM, 5'd7,  F3_LHU, 32'h4000_0000, 0, 1, 1, 32'h0000_8765, 0);
      @(negedge clk); op(WB_MEM, 5'd8,  3'b011, 32'h1000_0000, 0, 1, 0, 32'h0, 1);
      @(negedge clk); op(WB_MEM, 5'd9,  F3_LB,  32'h1000_0001, 0, 1, 1, 32'h0000_007F, 0);
      @(negedge clk); op(WB_MEM, 5'd10, F3_LW,  32'h8000_0000, 0, 1, 1, 32'hABCD_1234, 0);
      @(negedge clk); op(WB_MEM, 5'd11, F3_LH,  32'h1000_0002, 0, 1, 1, 32'hFFFF_80FF, 0);
      @(negedge clk); op(WB_MEM, 5'd12, F3_LW,  32'h1000_0003, 0, 1, 0, 32'h0, 1);
      idle(3);
   endtask
   task automatic test_stall;
      mem = {32'hABCD_1234, 32'h1234_8765, 32'h1234_5678};
      @(negedge clk); op(WB_ALU, 5'd8, 3'b0, 32'h77, 0, 1, 1, 32'h77, 0);
      @(negedge clk); op(WB_MEM, 5'd7, F3_LW, 32'h1000_0000, 0, 1, 1, 32'h1234_5678, 0);
      @(negedge clk); x_valid = 1'b0; stall = 1'b1;
      @(negedge clk); mem[31:0] = 32'h0;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge clk);
         total++;
         if ({wb_valid, wb_data, load_use} !== {1'b1, 32'h77, 1'b1}) begin
            bad++; $display("FAIL stall_hold_%0d got valid=%0b data=%h load_use=%0b expected 1 77 1", k, wb_valid, wb_data, load_use);
         end
      end
      stall = 1'b0;
      @(negedge clk);
      total++;
      if (wb_data !== 32'h1234_5678) begin
         bad++; $display("FAIL stall_held_word got %h expected 12345678", wb_data);
      end
      mem[31:0] = 32'hCAFE_F00D;
      op(WB_MEM, 5'd7, F3_LW, 32'h1000_0004, 0, 1, 1, 32'hCAFE_F00D, 0);
      idle(3);
   endtask
   task automatic test_fwd;
      mem[31:0] = 32'h600D_CAFE;
      @(negedge clk); op(WB_ALU, 5'd5, 3'b0, 32'h55, 32'h0, 1, 1, 32'h55, 0);
      @(negedge clk);
      total++;
      if ({fwd1_valid, fwd1_rd, fwd1_data, load_use} !== {1'b1, 5'd5, 32'h55, 1'b0}) begin
         bad++; $display("FAIL fwd_alu got v=%0b rd=%0d data=%h lu=%0b expected 1 5 55 0", fwd1_valid, fwd1_rd, fwd1_data, load_use);
      end
      op(WB_MEM, 5'd6, F3_LW, 32'h1000_0008, 0, 1, 1, 32'h600D_CAFE, 0);
      @(negedge clk);
      total++;
      if ({load_use, fwd1_valid} !== 2'b10) begin
         bad++; $display("FAIL fwd_load_use got lu=%0b fv=%0b expected 1 0", load_use, fwd1_valid);
      end
      op(WB_PC, 5'd13, 3'b0, 32'h9999, 32'h2004, 1, 1, 32'h2004, 0);
      @(negedge clk); x_valid = 1'b0;
      total++;
      if ({fwd1_valid, fwd1_data} !== {1'b1, 32'h2004}) begin
         bad++; $display("FAIL fwd_pc got v=%0b data=%h expected 1 2004", fwd1_valid, fwd1_data);
      end
      idle(3);
   endtask
   task automatic test_flush;
      @(negedge clk); op(WB_MEM, 5'd9, F3_LW, 32'h1000_0000, 0, 0, 0, 0, 0);
      @(negedge clk); x_valid = 1'b0; flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      op(WB_ALU, 5'd0, 3'b0, 32'h99, 0, 1, 0, 32'h99, 0);
      @(negedge clk); x_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({wb_valid, wb_we, wb_rd} !== {1'b1, 1'b0, 5'd0}) begin
         bad++; $display("FAIL flush_rd0 got v=%0b we=%0b rd=%0d expected 1 0 0", wb_valid, wb_we, wb_rd);
      end
      op(WB_MEM, 5'd11, F3_LW, 32'h1000_0000, 0, 0, 0, 0, 0);
      @(negedge clk); x_valid = 1'b0; flush = 1'b1; stall = 1'b1;
      @(negedge clk); flush = 1'b0; stall = 1'b0;
      total++;
      if (load_use !== 1'b0) begin
         bad++; $display("FAIL flush_over_stall got load_use=%0b expected 0", load_use);
      end
      op(WB_NONE, 5'd10, 3'b0, 32'h1234, 0, 1, 0, 32'h0, 0);
      idle(4);
   endtask
   task automatic test_reset_stall;
      mem[31:0] = 32'h1111_1111;
      @(negedge clk); op(WB_MEM, 5'd12, F3_LW, 32'h1000_0000, 0, 0, 0, 0, 0);
      @(negedge clk); x_valid = 1'b0; stall = 1'b1;
      @(negedge clk); rst_n = 1'b0; mem[31:0] = 32'h0BAD_F00D;
      @(negedge clk);
      total++;
      if ({fwd1_valid, fwd1_rd, fwd1_data, load_use, wb_valid, wb_we, wb_rd, wb_data, wb_err} !== '0) begin
         bad++; $display("FAIL reset_mid_stall got lu=%0b wv=%0b wd=%h expected all 0", load_use, wb_valid, wb_data);
      end
      rst_n = 1'b1; stall = 1'b0; sb.delete();
      @(negedge clk); op(WB_MEM, 5'd12, F3_LW, 32'h1000_0000, 0, 1, 1, 32'h0BAD_F00D, 0);
      idle(4);
   endtask
   initial begin
      test_reset;
      test_lw;
      test_align;
      test_stall;
      test_fwd;
      test_flush;
      test_reset_stall;
      total++;
      if (sb.size() != 0) begin
         bad++; $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_select_pipe.md
Name: wb_select_pipe

Overview:
- Parametrised two-stage writeback unit between the execute/memory-issue stage and the register file of the riscv_core.
- Replaces the combinational writeback mux with an N-source, address-tag-decoded memory selector.
- Adds load alignment and sign extension, a stall-safe read-data hold register, flush, forwarding taps and a load-use hazard flag.

Parameters:
XLEN, 32, datapath width
N_SRC, 3, number of readable memory sources (src0 dmem, src1 bios, src2 io)
TAG_W, 4, address tag width (addr[31:28])
SRC_TAG, {4'b1000,4'b0100,4'b0001}, packed N_SRC*TAG_W match values, src0 in LSBs
SRC_MASK, {4'b1111,4'b1111,4'b1101}, packed N_SRC*TAG_W masks; src i hits when (tag & mask_i) == tag_i

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
x_valid  in  1  instruction enters stage 1 this cycle
x_wb_sel  in  2  writeback source: `WB_NONE=00, `WB_ALU=01, `WB_MEM=10, `WB_PC=11
x_rd  in  5  destination register
x_funct3  in  3  load type (LB 000, LH 001, LW 010, LBU 100, LHU 101)
x_addr  in  XLEN  ALU result, used as load address
x_pc_plus4  in  XLEN  link value
mem_rdata  in  N_SRC*XLEN  synchronous-read data, valid the cycle after address issue
stall  in  1  hold both stages
flush  in  1  kill stage 1
fwd1_valid / fwd1_rd / fwd1_data  out  1/5/XLEN  stage-1 bypass (ALU/PC results only)
load_use  out  1  stage 1 holds a load with rd != 0
wb_valid / wb_we / wb_rd / wb_data  out  1/1/5/XLEN  stage-2 register-file write (also the stage-2 bypass)
wb_err  out  1  unmapped tag or misaligned load; valid with wb_valid

Behaviour:
- Reset (rst=0 at an edge): s1_valid=0, s2_valid=0, hold_valid=0. All outputs are 0.
- Edge T, x_valid=1 and no stall: s1 captures sel, rd, funct3, addr[1:0], tag, alu result and pc_plus4.
- Cycle T+1: s1 selects and aligns the result, which is registered into s2. wb_* are valid in cycle T+2. Latency is 2. Throughput is 1/cycle.
- Source decode: lowest-index hit among N_SRC wins. No hit → data 0, err=1.
- Load alignment:
  - LB/LBU: byte addr[1:0], sign- or zero-extended.
  - LH/LHU: half addr[1]; addr[0]=1 → err=1, data 0.
  - LW: addr[1:0] != 0 → err=1, data 0.
  - Undefined funct3 → err=1, data 0.
- WB_ALU gives the alu result. WB_PC gives pc_plus4. WB_NONE gives wb_we=0, data 0.
- wb_we = s2_valid & (sel != NONE) & (rd != 0) & !err.
- fwd1_valid = s1_valid & sel in {ALU, PC} & rd != 0. fwd1_data is the unaligned s1 value.
- load_use = s1_valid & sel == MEM & rd != 0.
- Stall:
  - s1 and s2 hold their contents.
  - On the first stall cycle with s1 holding a MEM op, the selected raw word is latched into the hold register and hold_valid=1.
  - While hold_valid=1, selection uses the held word, not mem_rdata.
  - hold_valid clears when s1 advances.
  - s2 holds and wb_* stay stable; the consumer must not double-write (wb_valid stays asserted).
- Flush: s1_valid=0 at the next edge and hold_valid=0. Flush overrides stall for s1. s2 is unaffected by flush and still obeys stall.
- x_valid while stalled is ignored; upstream must hold it.
- Reset mid-stall clears everything, including the hold register.

Decomposition:
- core_pkg/defines.vh: WB_* select encodings, funct3 load encodings, default tag constants.
- Sub-module load_align (combinational): inputs raw word, addr[1:0], funct3; outputs data and misalign.

Test Plan:
- LW src0 at x_addr=0x1000_0004, mem_rdata[src0]=0xDEAD_BEEF at T+1 → T+2: wb_data=0xDEAD_BEEF, wb_we=1, err=0.
- LB at 0x3000_0003 with word 0x80FF_7F01 → wb_data=0xFFFF_FF80 (tag 0011 hits src0 via mask). LBU same → 0x0000_0080.
- LH at 0x4000_0001 (bios, misaligned) → wb_err=1, wb_we=0, wb_data=0. Tag 0x2 (unmapped) LW → wb_err=1.
- LW then stall for 3 cycles, with mem_rdata changed to 0x0 after the first stall cycle → after release wb_data equals the original 0x1234_5678.
- ALU op rd=5 result 0x55 followed by a load rd=6:
  - cycle 1: fwd1_valid=1, fwd1_rd=5, fwd1_data=0x55.
  - next cycle: load_use=1, fwd1_valid=0.
- flush asserted with a load in s1, plus rd=0 ALU op → flushed op never reaches wb_valid. rd=0 op gives wb_valid=1, wb_we=0. Reset mid-stall → all outputs 0 next cycle.
